status_register_stack: RTL and testbench
========================================

// Module: status_register_stack
// PURPOSE
//  Parametrised processor status register (flag register) with a LIFO shadow stack.
//  - Captures ALU flags (default Z,N,C,V) under a per-bit write mask.
//  - Saves/restores the flag word on push/pop for calls and interrupts.
//  - Reports stack occupancy and sticky overflow/underflow errors.
//  - Sits between ALU flag outputs and control unit/branch logic; replaces the plain 4-bit flag latch.
// PARAMETERS
//  FLAG_W  4  flag word width; bit order {z,n,c,v} at default, MSB first
//  DEPTH   4  shadow stack entries, >=1; CNT_W = $clog2(DEPTH+1) (localparam)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  flags_in     in   FLAG_W   new flag values from ALU
//  flag_we      in   FLAG_W   per-bit write mask; bit i=1 loads flags_in[i]
//  push         in   1        save current flags_out onto stack
//  pop          in   1        restore flags_out from stack top
//  err_clr      in   1        clear sticky overflow/underflow
//  flags_out    out  FLAG_W   current status word (registered)
//  depth_cnt    out  CNT_W    valid stack entries, 0..DEPTH
//  full         out  1        depth_cnt==DEPTH (combinational from depth_cnt)
//  empty        out  1        depth_cnt==0 (combinational from depth_cnt)
//  overflow     out  1        sticky: push attempted while full
//  underflow    out  1        sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - flags_out=0, depth_cnt=0, overflow=0, underflow=0.
//   - Stack contents don't-care.
//   - Reset asserted mid-operation discards the stack immediately.
//  Timing: all updates on posedge clk; one-cycle latency from inputs to outputs; no handshake stall.
//  "masked write" (MW): flags_out <= (flags_out & ~flag_we) | (flags_in & flag_we).
//  Per-cycle operation, decided by {push,pop}:
//   00: MW only.
//   10, not full: stack[depth_cnt] <= flags_out (pre-MW value); depth_cnt++; MW applies same cycle.
//   10, full: overflow <= 1; stack and depth_cnt unchanged; MW applies.
//   01, not empty: flags_out <= stack[depth_cnt-1]; depth_cnt--; flag_we ignored (pop beats write).
//   01, empty: underflow <= 1; MW applies.
//   11, not empty: exchange; stack top <= flags_out, flags_out <= old top; depth_cnt unchanged; flag_we ignored.
//   11, empty: underflow <= 1; nothing pushed; MW applies.
//  Sticky errors:
//   - Stay set until err_clr=1.
//   - If err_clr coincides with a new error of the same kind, set wins.
//  Stack is indexed storage with pointer = depth_cnt; no wrap-around, since full/empty guards prevent it.
//  FLAG_W=4, DEPTH=1, push=pop=0 at all times, flag_we=4'hF reproduces the legacy 4-bit flag register.
// TESTING
//  1 Reset: rst_n=0 mid-stream with depth_cnt=2 -> flags_out=0, depth_cnt=0, empty=1, errors=0, async (before clk).
//  2 Mask: flags_out=4'b1010, flags_in=4'b0101, flag_we=4'b0011 -> next flags_out=4'b1001.
//  3 Push/pop round trip: flags 4'hA push, MW to 4'h3, pop -> flags_out=4'hA, depth_cnt 0->1->0.
//     - Push-cycle MW visible next cycle.
//  4 Overflow (DEPTH=4): 5 pushes of 1,2,3,4,5 -> full=1, overflow=1 after 5th.
//     - 4 pops yield 4,3,2,1 (5 never stored); err_clr -> overflow=0.
//  5 Underflow/priority: pop on empty with flag_we=4'hF, flags_in=4'h6 -> underflow=1, flags_out=6.
//     - err_clr+pop-empty same cycle -> underflow stays 1.
//  6 Exchange: stack top=4'h5, flags_out=4'hC, push=pop=1, flag_we=4'hF -> flags_out=5, top=C, depth_cnt unchanged.

Source files
------------

// File: rtl/status_register_stack.sv
// Processor status (flag) register with a per-bit write mask and a LIFO shadow stack
// for saving/restoring the flag word across calls and interrupts.
module status_register_stack #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] flag_we,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [FLAG_W-1:0] flags_out,
    output logic [CNT_W-1:0]  depth_cnt,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    logic [FLAG_W-1:0] flags_reg, flags_next;
    logic [CNT_W-1:0]  depth_reg, depth_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;

    logic              full_w, empty_w;
    logic              do_push, do_pop, do_xchg;
    logic              ovf_set, unf_set;
    logic [FLAG_W-1:0] masked_word;
    logic [FLAG_W-1:0] top_word;

    logic [DEPTH-1:0]             wr_en;
    logic [DEPTH-1:0]             top_sel;
    logic [DEPTH-1:0][FLAG_W-1:0] top_terms;

    assign full_w  = (depth_reg == CNT_W'(DEPTH));
    assign empty_w = (depth_reg == '0);

    // Exchange (push+pop) is only legal with something on the stack; a lone push
    // is refused when full, a lone pop when empty.
    assign do_push = push & ~pop & ~full_w;
    assign do_pop  = pop & ~push & ~empty_w;
    assign do_xchg = push & pop & ~empty_w;
    assign ovf_set = push & ~pop & full_w;
    assign unf_set = pop & empty_w;

    assign masked_word = (flags_reg & ~flag_we) | (flags_in & flag_we);

    // One register per stack slot; the occupancy count is the write pointer,
    // and the slot below it is the top.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [FLAG_W-1:0] entry_reg;

            assign wr_en[gi]   = (do_push && (depth_reg == CNT_W'(gi)))
                              || (do_xchg && (depth_reg == CNT_W'(gi + 1)));
            assign top_sel[gi] = (depth_reg == CNT_W'(gi + 1));
            assign top_terms[gi] = top_sel[gi] ? entry_reg : '0;

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    entry_reg <= flags_reg;
                end
            end
        end
    endgenerate

    always_comb begin
        top_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            top_word = top_word | top_terms[i];
        end
    end

    always_comb begin
        flags_next = masked_word;
        depth_next = depth_reg;
        if (do_pop || do_xchg) begin
            flags_next = top_word;
        end
        if (do_push) begin
            depth_next = depth_reg + CNT_W'(1);
        end else if (do_pop) begin
            depth_next = depth_reg - CNT_W'(1);
        end
        // A fresh error wins over a simultaneous clear.
        ovf_next = ovf_set | (ovf_reg & ~err_clr);
        unf_next = unf_set | (unf_reg & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= '0;
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            flags_reg <= flags_next;
            depth_reg <= depth_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign flags_out = flags_reg;
    assign depth_cnt = depth_reg;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;

endmodule

// File: tb/tb_status_register_stack.sv
// Directed, table-driven check of status_register_stack (FLAG_W=4, DEPTH=4)
// plus hand-written sequences for async reset and error-clear priority.
module tb_status_register_stack;

    localparam int FLAG_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic [FLAG_W-1:0] flags_in;
    logic [FLAG_W-1:0] flag_we;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [FLAG_W-1:0] flags_out;
    logic [CNT_W-1:0]  depth_cnt;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    int n_cmp = 0;
    int n_bad = 0;

    status_register_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flags_in  (flags_in),
        .flag_we   (flag_we),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .flags_out (flags_out),
        .depth_cnt (depth_cnt),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       push;
        logic       pop;
        logic       err_clr;
        logic [3:0] flags_in;
        logic [3:0] flag_we;
        logic [3:0] exp_flags;
        logic [2:0] exp_depth;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic ps, input logic pp, input logic ec,
                       input logic [3:0] fi, input logic [3:0] we,
                       input logic [3:0] ef, input logic [2:0] ed,
                       input logic eo, input logic eu);
        vec_t v;
        v.name = nm; v.push = ps; v.pop = pp; v.err_clr = ec;
        v.flags_in = fi; v.flag_we = we;
        v.exp_flags = ef; v.exp_depth = ed; v.exp_ovf = eo; v.exp_unf = eu;
        vecs.push_back(v);
    endtask

    // Packed view: {flags, depth, full, empty, overflow, underflow}
    task automatic check(input string nm, input logic [3:0] ef, input logic [2:0] ed,
                         input logic ef_full, input logic ef_empty,
                         input logic eo, input logic eu);
        logic [10:0] act, exp;
        act = {flags_out, depth_cnt, full, empty, overflow, underflow};
        exp = {ef, ed, ef_full, ef_empty, eo, eu};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got flags=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, want flags=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                     nm, flags_out, depth_cnt, full, empty, overflow, underflow,
                     ef, ed, ef_full, ef_empty, eo, eu);
        end else begin
            $display("ok   %s: flags=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                     nm, flags_out, depth_cnt, full, empty, overflow, underflow);
        end
    endtask

    task automatic drive(input logic ps, input logic pp, input logic ec,
                         input logic [3:0] fi, input logic [3:0] we);
        push = ps; pop = pp; err_clr = ec; flags_in = fi; flag_we = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 4'h0, 4'h0);

        //   name             ps pp ec  in    we    flags depth ovf unf
        add("mw_load_A",      0, 0, 0, 4'hA, 4'hF, 4'hA, 3'd0, 0, 0);
        add("mw_mask_0011",   0, 0, 0, 4'h5, 4'h3, 4'h9, 3'd0, 0, 0);
        add("mw_reload_A",    0, 0, 0, 4'hA, 4'hF, 4'hA, 3'd0, 0, 0);
        add("push_A_mw_3",    1, 0, 0, 4'h3, 4'hF, 4'h3, 3'd1, 0, 0);
        add("pop_restore_A",  0, 1, 0, 4'hF, 4'hF, 4'hA, 3'd0, 0, 0);
        add("mw_load_1",      0, 0, 0, 4'h1, 4'hF, 4'h1, 3'd0, 0, 0);
        add("push_1",         1, 0, 0, 4'h2, 4'hF, 4'h2, 3'd1, 0, 0);
        add("push_2",         1, 0, 0, 4'h3, 4'hF, 4'h3, 3'd2, 0, 0);
        add("push_3",         1, 0, 0, 4'h4, 4'hF, 4'h4, 3'd3, 0, 0);
        add("push_4_full",    1, 0, 0, 4'h5, 4'hF, 4'h5, 3'd4, 0, 0);
        add("push_5_ovf",     1, 0, 0, 4'h6, 4'hF, 4'h6, 3'd4, 1, 0);
        add("pop_4",          0, 1, 0, 4'h0, 4'hF, 4'h4, 3'd3, 1, 0);
        add("pop_3",          0, 1, 0, 4'h0, 4'hF, 4'h3, 3'd2, 1, 0);
        add("pop_2",          0, 1, 0, 4'h0, 4'hF, 4'h2, 3'd1, 1, 0);
        add("pop_1",          0, 1, 0, 4'h0, 4'hF, 4'h1, 3'd0, 1, 0);
        add("clr_ovf",        0, 0, 1, 4'h0, 4'h0, 4'h1, 3'd0, 0, 0);
        add("pop_empty_unf",  0, 1, 0, 4'h6, 4'hF, 4'h6, 3'd0, 0, 1);
        add("clr_and_unf",    0, 1, 1, 4'h9, 4'h0, 4'h6, 3'd0, 0, 1);
        add("clr_unf",        0, 0, 1, 4'h0, 4'h0, 4'h6, 3'd0, 0, 0);
        add("xchg_empty_unf", 1, 1, 0, 4'h7, 4'hF, 4'h7, 3'd0, 0, 1);
        add("clr_unf2",       0, 0, 1, 4'h0, 4'h0, 4'h7, 3'd0, 0, 0);
        add("mw_load_5",      0, 0, 0, 4'h5, 4'hF, 4'h5, 3'd0, 0, 0);
        add("push_5_mw_C",    1, 0, 0, 4'hC, 4'hF, 4'hC, 3'd1, 0, 0);
        add("xchg_5_C",       1, 1, 0, 4'h0, 4'hF, 4'h5, 3'd1, 0, 0);
        add("pop_top_is_C",   0, 1, 0, 4'h0, 4'hF, 4'hC, 3'd0, 0, 0);

        #1;
        check("reset_state", 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #13;
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].err_clr,
                  vecs[i].flags_in, vecs[i].flag_we);
            step();
            check(vecs[i].name, vecs[i].exp_flags, vecs[i].exp_depth,
                  vecs[i].exp_depth == 3'd4, vecs[i].exp_depth == 3'd0,
                  vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Overflow set coinciding with err_clr: set must win.
        drive(0, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 4'(i + 1), 4'hF);
            step();
        end
        check("refill_full", 4'h4, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1, 0, 1, 4'h8, 4'hF);
        step();
        check("clr_and_ovf", 4'h8, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);

        // Async reset mid-cycle with depth 2: takes effect before any clock edge.
        drive(0, 1, 0, 4'h0, 4'h0);
        step();
        step();
        check("pre_reset_d2", 4'h2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(0, 0, 0, 4'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        drive(0, 1, 0, 4'h3, 4'h0);
        step();
        check("pop_after_reset", 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
